// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_pkg
// Description : AXI4 burst/response encodings and responder FSM state types.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axi4_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_if
// Description : AXI4 bus interface with master and slave modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BUS_LEN_WIDTH = 5,
    parameter int ID_WIDTH      = 4
);
    logic [ID_WIDTH-1:0]      awid;
    logic [ADDR_WIDTH-1:0]    awaddr;
    logic [BUS_LEN_WIDTH-1:0] awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awlock;
    logic [3:0]               awcache;
    logic [2:0]               awprot;
    logic [3:0]               awqos;
    logic [3:0]               awregion;
    logic                     awuser;
    logic                     awvalid;
    logic                     awready;

    logic [ID_WIDTH-1:0]      wid;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH/8-1:0]  wstrb;
    logic                     wlast;
    logic                     wuser;
    logic                     wvalid;
    logic                     wready;

    logic [ID_WIDTH-1:0]      bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic [ID_WIDTH-1:0]      arid;
    logic [ADDR_WIDTH-1:0]    araddr;
    logic [BUS_LEN_WIDTH-1:0] arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arlock;
    logic [3:0]               arcache;
    logic [2:0]               arprot;
    logic [3:0]               arqos;
    logic [3:0]               arregion;
    logic                     aruser;
    logic                     arvalid;
    logic                     arready;

    logic [ID_WIDTH-1:0]      rid;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master_mp (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave_mp (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface
`default_nettype wire

// File: rtl/axi4_ram_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi4_ram_mem
// Description : Simple dual-port RAM, byte-enabled write, registered read
//               (1-cycle latency, read-during-write returns old data).
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_ram_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [$clog2(DEPTH)-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    input  logic [DATA_WIDTH/8-1:0]       i_wbe,
    input  logic                          i_re,
    input  logic [$clog2(DEPTH)-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0]         o_rdata
);
    localparam int c_bytes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Output holds while i_re is low so a stalled read beat stays stable.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
        if (i_we) begin
            for (int b = 0; b < c_bytes; b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi4_slave_ram.sv
`default_nettype none
// ============================================================================
// Module      : axi4_slave_ram
// Description : AXI4 responder backed by on-chip RAM; independent single-burst
//               write and read paths. Define AXI4_SLAVE_RAM_STRB_EN for wstrb.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_slave_ram #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BUS_LEN_WIDTH = 5,
    parameter int ID_WIDTH      = 4,
    parameter int MEM_WORDS     = 1024
) (
    input  logic      clk,
    input  logic      rst,
    axi4_if.slave_mp  s_axi
);
    import axi4_pkg::*;

    localparam int c_bytes   = DATA_WIDTH / 8;
    localparam int c_size_lg = $clog2(c_bytes);
    localparam int c_idx_w   = $clog2(MEM_WORDS);
    localparam int c_ext_w   = ADDR_WIDTH + BUS_LEN_WIDTH + 4;
    localparam logic [c_ext_w-1:0] c_mem_bytes = c_ext_w'(MEM_WORDS) * c_ext_w'(c_bytes);

    function automatic logic [c_idx_w-1:0] f_idx(input logic [ADDR_WIDTH-1:0] addr);
        return c_idx_w'(addr >> c_size_lg);
    endfunction

    function automatic logic [1:0] f_check(input logic [ADDR_WIDTH-1:0]    addr,
                                           input logic [BUS_LEN_WIDTH-1:0] len,
                                           input logic [2:0]               size,
                                           input logic [1:0]               burst);
        logic [c_ext_w-1:0] end_addr;
        end_addr = c_ext_w'(addr) + ((c_ext_w'(len) + c_ext_w'(1)) << c_size_lg);
        if (size != 3'(c_size_lg) || burst == BURST_WRAP || burst == 2'b11)
            return RESP_SLVERR;
        else if (burst == BURST_INCR && end_addr > c_mem_bytes)
            return RESP_DECERR;
        else if (burst == BURST_FIXED && c_ext_w'(addr) >= c_mem_bytes)
            return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    // ---------------------------------------------------------------- write
    wr_state_e                r_wstate;
    logic                     r_awready, r_wready, r_bvalid, r_wok, r_wfixed;
    logic [ID_WIDTH-1:0]      r_bid;
    logic [1:0]               r_bresp;
    logic [c_idx_w-1:0]       r_widx;
    logic [BUS_LEN_WIDTH-1:0] r_wbeat, r_wlen;

    logic [1:0]               w_aw_status;
    logic                     w_wfire, w_wfinal, w_we;
    logic [c_bytes-1:0]       w_wbe;

    assign w_aw_status = f_check(s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst);
    assign w_wfire     = s_axi.wvalid && r_wready;
    assign w_wfinal    = (r_wbeat == r_wlen);
    assign w_we        = w_wfire && r_wok;
`ifdef AXI4_SLAVE_RAM_STRB_EN
    assign w_wbe       = s_axi.wstrb;
`else
    assign w_wbe       = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= RESP_OKAY;
            r_wok     <= 1'b0;
            r_wfixed  <= 1'b0;
            r_widx    <= '0;
            r_wbeat   <= '0;
            r_wlen    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (r_awready && s_axi.awvalid) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= s_axi.awid;
                        r_bresp   <= w_aw_status;
                        r_wok     <= (w_aw_status == RESP_OKAY);
                        r_wfixed  <= (s_axi.awburst == BURST_FIXED);
                        r_widx    <= f_idx(s_axi.awaddr);
                        r_wbeat   <= '0;
                        r_wlen    <= s_axi.awlen;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_wfire) begin
                        // The beat count ends the burst; a misplaced wlast only taints the response.
                        if (s_axi.wlast != w_wfinal && r_bresp != RESP_DECERR)
                            r_bresp <= RESP_SLVERR;
                        if (w_wfinal) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wbeat <= r_wbeat + 1'b1;
                            if (!r_wfixed)
                                r_widx <= r_widx + 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- read
    rd_state_e                r_rstate;
    logic                     r_arready, r_rvalid, r_rlast, r_rok, r_rfixed;
    logic [ID_WIDTH-1:0]      r_rid;
    logic [1:0]               r_rresp;
    logic [c_idx_w-1:0]       r_ridx;
    logic [BUS_LEN_WIDTH-1:0] r_rbeat, r_rlen;

    logic [1:0]               w_ar_status;
    logic                     w_arfire, w_rfire, w_re;
    logic [c_idx_w-1:0]       w_aridx, w_ridx_next, w_raddr;
    logic [DATA_WIDTH-1:0]    w_rdq;

    assign w_ar_status = f_check(s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst);
    assign w_aridx     = f_idx(s_axi.araddr);
    assign w_arfire    = r_arready && s_axi.arvalid;
    assign w_rfire     = r_rvalid && s_axi.rready;
    assign w_ridx_next = r_rfixed ? r_ridx : r_ridx + 1'b1;

    // Fetch beat 0 on AR accept, and the next beat on each non-final R accept.
    always_comb begin
        w_re    = 1'b0;
        w_raddr = r_ridx;
        if (r_rstate == R_IDLE && w_arfire) begin
            w_re    = (w_ar_status == RESP_OKAY);
            w_raddr = w_aridx;
        end else if (r_rstate == R_DATA && w_rfire && !r_rlast) begin
            w_re    = r_rok;
            w_raddr = w_ridx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rresp   <= RESP_OKAY;
            r_rok     <= 1'b0;
            r_rfixed  <= 1'b0;
            r_ridx    <= '0;
            r_rbeat   <= '0;
            r_rlen    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_arfire) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rid     <= s_axi.arid;
                        r_rresp   <= w_ar_status;
                        r_rok     <= (w_ar_status == RESP_OKAY);
                        r_rfixed  <= (s_axi.arburst == BURST_FIXED);
                        r_ridx    <= w_aridx;
                        r_rbeat   <= '0;
                        r_rlen    <= s_axi.arlen;
                        r_rlast   <= (s_axi.arlen == '0);
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_rfire) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rbeat <= r_rbeat + 1'b1;
                            r_ridx  <= w_ridx_next;
                            r_rlast <= ((r_rbeat + 1'b1) == r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    axi4_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_WORDS)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wdata (s_axi.wdata),
        .i_wbe   (w_wbe),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdq)
    );

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bid     = r_bid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rlast   = r_rlast;
    assign s_axi.rid     = r_rid;
    assign s_axi.rresp   = r_rresp;
    // Errored bursts (and the reset state) present all-zero read data.
    assign s_axi.rdata   = r_rok ? w_rdq : '0;

    logic w_unused_sigs;
    assign w_unused_sigs = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                             s_axi.awregion, s_axi.awuser, s_axi.wid, s_axi.wuser,
                             s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                             s_axi.arregion, s_axi.aruser, s_axi.awaddr, s_axi.araddr,
                             s_axi.wstrb};

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_slave_ram
// Description : Table-driven self-checking bench for axi4_slave_ram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_slave_ram;
    import axi4_pkg::*;

    localparam int c_n_vec = 16;

    logic clk;
    logic rst;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BUS_LEN_WIDTH(5), .ID_WIDTH(4)) bus ();

    axi4_slave_ram #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .BUS_LEN_WIDTH (5),
        .ID_WIDTH      (4),
        .MEM_WORDS     (1024)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus)
    );

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [4:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] d0;       // write data / expected read data for beat 0
        logic [31:0] dstep;    // per-beat increment of that data
        logic [3:0]  strb;
        bit          bad_last;
        bit          lock;
        logic [3:0]  rpat;     // rready pattern, bit (cycle % 4)
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs [c_n_vec];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input vec_t v);
        int k;
        bus.awid    = v.id;
        bus.awaddr  = v.addr;
        bus.awlen   = v.len;
        bus.awsize  = v.size;
        bus.awburst = v.burst;
        bus.awlock  = v.lock;
        bus.awvalid = 1'b1;
        k = 0;
        while (!bus.awready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) begin check("aw_timeout", 0, 1); bus.awvalid = 1'b0; return; end
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.awlock  = 1'b0;
        check("wready_after_aw", bus.wready, 1);
        check("awready_busy", bus.awready, 0);
        for (int i = 0; i <= int'(v.len); i++) begin
            bus.wdata  = v.d0 + 32'(i) * v.dstep;
            bus.wstrb  = v.strb;
            bus.wlast  = v.bad_last ? 1'b1 : (i == int'(v.len));
            bus.wvalid = 1'b1;
            k = 0;
            while (!bus.wready && k < 50) begin @(negedge clk); k++; end
            if (k >= 50) begin check("w_timeout", 0, 1); break; end
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        check("bvalid", bus.bvalid, 1);
        check("bid", bus.bid, v.id);
        check("bresp", bus.bresp, v.resp);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("awready_after_b", bus.awready, 1);
        check("bvalid_drop", bus.bvalid, 0);
    endtask

    task automatic do_read(input vec_t v);
        int          k, beat, c;
        bit          stalled, rr;
        logic [31:0] held;
        bus.arid    = v.id;
        bus.araddr  = v.addr;
        bus.arlen   = v.len;
        bus.arsize  = v.size;
        bus.arburst = v.burst;
        bus.arvalid = 1'b1;
        k = 0;
        while (!bus.arready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) begin check("ar_timeout", 0, 1); bus.arvalid = 1'b0; return; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        beat = 0; c = 0; stalled = 1'b0; held = '0;
        while (beat <= int'(v.len) && c < 200) begin
            check("rvalid", bus.rvalid, 1);
            if (stalled) check("rdata_hold", bus.rdata, held);
            rr = v.rpat[c % 4];
            bus.rready = rr;
            if (rr) begin
                check("rdata", bus.rdata, v.d0 + 32'(beat) * v.dstep);
                check("rresp", bus.rresp, v.resp);
                check("rid", bus.rid, v.id);
                check("rlast", bus.rlast, (beat == int'(v.len)));
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = bus.rdata;
            end
            @(negedge clk);
            c++;
        end
        bus.rready = 1'b0;
        if (beat <= int'(v.len)) check("r_timeout", 0, 1);
        check("arready_after_rlast", bus.arready, 1);
        check("rvalid_drop", bus.rvalid, 0);
    endtask

    initial begin
        vec_t v;
        int   k;
        //           wr    id     addr         len    sz    burst        d0            dstep       strb  bl  lk  rpat   resp
        vecs[0]  = '{1'b1, 4'h3, 32'h0000_0010, 5'd3, 3'd2, BURST_INCR,  32'h0000_00A0, 32'h1,     4'hF, 1'b0, 1'b0, 4'hF, RESP_OKAY};
        vecs[1]  = '{1'b0, 4'h5, 32'h0000_0010, 5'd3, 3'd2, BURST_INCR,  32'h0000_00A0, 32'h1,     4'hF, 1'b0, 1'b0, 4'hF, RESP_OKAY};
        vecs[2]  = '{1'b1, 4'h1, 32'h0000_0020, 5'd1, 3'd2, BURST_FIXED, 32'h0000_0011, 32'h11,    4'hF, 1'b0, 1'b1, 4'hF, RESP_OKAY};
        vecs[3]  = '{1'b0, 4'h2, 32'h0000_0020, 5'd0, 3'd2, BURST_INCR,  32'h0000_0022, 32'h0,     4'hF, 1'b0, 1'b0, 4'hF, RESP_OKAY};
        vecs[4]  = '{1'b1, 4'h4, 32'h0000_0FF8, 5'd1, 3'd2, BURST_INCR,  32'h0000_0055, 32'h10,    4'hF, 1'b0, 1'b0, 4'hF, RESP_OKAY};
        vecs[5]  = '{1'b1, 4'h6, 32'h0000_0FFC, 5'd1, 3'd2, BURST_INCR,  32'hDEAD_0000, 32'h1,     4'hF, 1'b0, 1'b0, 4'hF, RESP_DECERR};
        vecs[6]  = '{1'b0, 4'h7, 32'h0000_0FF8, 5'd1, 3'd2, BURST_INCR,  32'h0000_0055, 32'h10,    4'hF, 1'b0, 1'b0, 4'hF, RESP_OKAY};
        vecs[7]  = '{1'b0, 4'h8, 32'h0000_0FFC, 5'd2, 3'd2, BURST_FIXED, 32'h0000_0065, 32'h0,     4'hF, 1'b0, 1'b0, 4'hF, RESP_OKAY};
        vecs[8]  = '{1'b0, 4'h9, 32'h0000_0040, 5'd3, 3'd2, BURST_WRAP,  32'h0,         32'h0,     4'hF, 1'b0, 1'b0, 4'hF, RESP_SLVERR};
        vecs[9]  = '{1'b0, 4'hA, 32'h0000_0010, 5'd0, 3'd1, BURST_INCR,  32'h0,         32'h0,     4'hF, 1'b0, 1'b0, 4'hF, RESP_SLVERR};
        vecs[10] = '{1'b1, 4'hB, 32'h0000_1000, 5'd0, 3'd2, BURST_FIXED, 32'hBAD0_0000, 32'h0,     4'hF, 1'b0, 1'b0, 4'hF, RESP_DECERR};
        vecs[11] = '{1'b0, 4'hC, 32'h0000_1000, 5'd0, 3'd2, BURST_FIXED, 32'h0,         32'h0,     4'hF, 1'b0, 1'b0, 4'hF, RESP_DECERR};
        vecs[12] = '{1'b1, 4'hD, 32'h0000_0030, 5'd1, 3'd2, BURST_INCR,  32'h0000_0077, 32'h1,     4'hF, 1'b1, 1'b0, 4'hF, RESP_SLVERR};
        vecs[13] = '{1'b1, 4'hE, 32'h0000_0100, 5'd7, 3'd2, BURST_INCR,  32'h0000_1000, 32'h1,     4'hF, 1'b0, 1'b0, 4'hF, RESP_OKAY};
        vecs[14] = '{1'b0, 4'hF, 32'h0000_0100, 5'd7, 3'd2, BURST_INCR,  32'h0000_1000, 32'h1,     4'hF, 1'b0, 1'b0, 4'b1001, RESP_OKAY};
        vecs[15] = '{1'b0, 4'h1, 32'h0000_0FFC, 5'd1, 3'd2, BURST_INCR,  32'h0,         32'h0,     4'hF, 1'b0, 1'b0, 4'hF, RESP_DECERR};

        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = BURST_INCR;
        bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
        bus.awuser = 1'b0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wuser = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = BURST_INCR;
        bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
        bus.aruser = 1'b0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
        check("rst_valids", {bus.bvalid, bus.rvalid, bus.rlast}, 0);
        check("rst_resp_id", {bus.bresp, bus.bid, bus.rresp, bus.rid}, 0);
        check("rst_rdata", bus.rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        check("awready_after_rst", bus.awready, 1);
        check("arready_after_rst", bus.arready, 1);

        for (int i = 0; i < c_n_vec; i++) begin
            if (vecs[i].wr) do_write(vecs[i]);
            else            do_read(vecs[i]);
        end

        // Strobed partial write to word 0.
        v = '{1'b1, 4'h2, 32'h0, 5'd0, 3'd2, BURST_INCR, 32'hFFFF_FFFF, 32'h0, 4'hF, 1'b0, 1'b0, 4'hF, RESP_OKAY};
        do_write(v);
        v.d0 = 32'h1234_5678; v.strb = 4'b0101;
        do_write(v);
        v.wr = 1'b0;
`ifdef AXI4_SLAVE_RAM_STRB_EN
        v.d0 = 32'hFF34_FF78;
`else
        v.d0 = 32'h1234_5678;
`endif
        do_read(v);

        // Reset in the middle of an 8-beat read, after beat 1 is accepted.
        bus.arid = 4'h9; bus.araddr = 32'h100; bus.arlen = 5'd7; bus.arsize = 3'd2;
        bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
        k = 0;
        while (!bus.arready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) check("ar_timeout_rst", 0, 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        check("rst_seq_beat0", bus.rdata, 32'h1000);
        @(negedge clk);
        check("rst_seq_beat1", bus.rdata, 32'h1001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rvalid_in_rst", bus.rvalid, 0);
        check("arready_in_rst", bus.arready, 0);
        check("rdata_in_rst", bus.rdata, 0);
        rst = 1'b0;
        bus.rready = 1'b0;
        @(negedge clk);
        check("arready_post_rst", bus.arready, 1);
        check("rvalid_post_rst", bus.rvalid, 0);

        v = '{1'b0, 4'h3, 32'h100, 5'd0, 3'd2, BURST_INCR, 32'h1000, 32'h0, 4'hF, 1'b0, 1'b0, 4'hF, RESP_OKAY};
        do_read(v);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
